// File: rtl/fetch_line_streamer.sv
// Fetch line streamer: turns a redirect target into sequential 16-byte I-cache line requests
// and buffers each returned line toward the instruction queue. Stats option: FETCH_LINE_STREAMER_STATS_EN.
module fetch_line_streamer #(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_addr,
   output logic                  ic_req_valid,
   input  logic                  ic_req_ready,
   output logic [ADDR_WIDTH-1:0] ic_req_addr,
   input  logic                  ic_rsp_valid,
   input  logic [127:0]          ic_rsp_data,
   output logic                  q_valid,
   input  logic                  q_ready,
   output logic [127:0]          q_data,
   output logic                  q_load,
   output logic [5:0]            q_load_address,
   output logic [15:0]           lines_delivered,
   output logic [15:0]           lines_dropped
);

   // state | meaning
   // IDLE  | after reset, waiting for the first redirect
   // REQ   | offering the next line request
   // WAIT  | one live request outstanding
   // DROP  | one stale request outstanding, its data is discarded
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] next_line;
   logic                  buf_valid;
   logic [127:0]          buf_data;
   logic                  load_pend;
   logic                  req_fire;
   logic                  rsp_capture;
   logic                  q_fire;

   // Only request when the buffer is certain to be free by the time the line returns.
   assign ic_req_valid   = (state == REQ) && (!buf_valid || q_ready) && !redirect_valid;
   assign ic_req_addr    = next_line;
   assign req_fire       = ic_req_valid && ic_req_ready;
   assign rsp_capture    = (state == WAIT) && ic_rsp_valid && !redirect_valid;
   assign q_valid        = buf_valid;
   assign q_data         = buf_data;
   assign q_load         = load_pend;
   assign q_fire         = buf_valid && q_ready;

   always_comb begin
      state_nxt = state;
      if (redirect_valid) begin
         if ((state == WAIT || state == DROP) && !ic_rsp_valid)
            state_nxt = DROP;
         else
            state_nxt = REQ;
      end else begin
         case (state)
            IDLE:       state_nxt = IDLE;
            REQ:        if (req_fire) state_nxt = WAIT;
            WAIT, DROP: if (ic_rsp_valid) state_nxt = REQ;
            default:    state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         next_line      <= '0;
         buf_valid      <= 1'b0;
         buf_data       <= '0;
         load_pend      <= 1'b0;
         q_load_address <= '0;
      end else begin
         state     <= state_nxt;
         load_pend <= redirect_valid;
         if (redirect_valid) begin
            next_line      <= {redirect_addr[ADDR_WIDTH-1:4], 4'h0};
            q_load_address <= {2'b00, redirect_addr[3:0]};
         end else if (req_fire) begin
            next_line <= next_line + ADDR_WIDTH'(16);
         end
         if (redirect_valid) begin
            buf_valid <= 1'b0;
         end else if (rsp_capture) begin
            buf_valid <= 1'b1;
            buf_data  <= ic_rsp_data;
         end else if (q_fire) begin
            buf_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_LINE_STREAMER_STATS_EN
   logic        drop_evt;
   logic [15:0] delivered_cnt;
   logic [15:0] dropped_cnt;

   // A live response coinciding with a redirect is discarded just like a stale one.
   assign drop_evt = ic_rsp_valid && ((state == DROP) || (state == WAIT && redirect_valid));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         delivered_cnt <= '0;
         dropped_cnt   <= '0;
      end else begin
         if (q_fire && delivered_cnt != 16'hFFFF)
            delivered_cnt <= delivered_cnt + 16'd1;
         if (drop_evt && dropped_cnt != 16'hFFFF)
            dropped_cnt <= dropped_cnt + 16'd1;
      end
   end

   assign lines_delivered = delivered_cnt;
   assign lines_dropped   = dropped_cnt;
`else
   assign lines_delivered = '0;
   assign lines_dropped   = '0;
`endif

endmodule

// File: doc/fetch_line_streamer.md
# fetch_line_streamer

Producer side of the instruction queue's line input. It turns a redirect target into a stream of sequential 16-byte-aligned I-cache line requests. Each returned 128-bit line is pushed to the instruction queue over valid/ready. Queue flushes (`q_load`/`q_load_address`) are issued on redirect, and in-flight responses made stale by a redirect are discarded.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: fetch address width; line offset is always bits [3:0].

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  one-cycle redirect request (branch/reset vector).
- `redirect_addr`  in  ADDR_WIDTH  byte target address.
- `ic_req_valid`  out  1  I-cache line request valid.
- `ic_req_ready`  in  1  I-cache accepts request.
- `ic_req_addr`  out  ADDR_WIDTH  line-aligned request address; bits [3:0] always 0.
- `ic_rsp_valid`  in  1  response line valid; never backpressured.
- `ic_rsp_data`  in  128  response line, byte 0 in bits [7:0].
- `q_valid`  out  1  line available to queue.
- `q_ready`  in  1  queue accepts line.
- `q_data`  out  128  line to queue.
- `q_load`  out  1  one-cycle queue flush.
- `q_load_address`  out  6  new queue head, `{2'b00, redirect_addr[3:0]}`.
- `lines_delivered`  out  16  stats counter (see Configuration).
- `lines_dropped`  out  16  stats counter (see Configuration).

## Operation
- State machine states:
  - `IDLE`: reset state; waits for the first redirect.
  - `REQ`: issuing a request.
  - `WAIT`: one request outstanding.
  - `DROP`: one stale request outstanding.
- Registers:
  - `next_line`: next line address.
  - `buf_valid`/`buf_data`: one-entry output buffer.
  - `load_pend`: drives `q_load`.
- `ic_req_valid = (state==REQ) && (!buf_valid || q_ready) && !redirect_valid`. A request is issued only when the buffer is guaranteed free when its response returns. At most one request is outstanding.
- `ic_req_addr = next_line`. On a request handshake, `next_line <= next_line + 16` (modulo 2^ADDR_WIDTH, so 0xFFFFFFF0 wraps to 0x00000000) and REQ→WAIT.
- WAIT with `ic_rsp_valid`: `buf_data <= ic_rsp_data`, `buf_valid <= 1`, go to REQ.
- DROP with `ic_rsp_valid`: discard the data, go to REQ.
- Queue handshake: `q_valid = buf_valid`, `q_data = buf_data`. When `q_valid && q_ready`, `buf_valid` clears unless it is refilled in the same cycle.
- Redirect has priority over everything in every state:
  - `next_line <= {redirect_addr[ADDR_WIDTH-1:4], 4'h0}`; `buf_valid <= 0`; `load_pend <= 1`; `q_load_address <= {2'b00, redirect_addr[3:0]}`.
  - Next state:
    - From WAIT without a same-cycle response, or from DROP without a same-cycle response: DROP.
    - From WAIT or DROP with a same-cycle `ic_rsp_valid`: that response is discarded and the state goes to REQ.
    - From IDLE or REQ: REQ. No request is issued in the redirect cycle.
- A queue handshake in the redirect cycle still counts as delivered; the line is flushed by the following `q_load`.

## Timing
- Reset values: all outputs 0, state IDLE, `next_line` 0. Reset is honoured mid-transaction; any late response arriving in IDLE is ignored.
- Redirect at cycle N:
  - `q_load`=1 for cycle N+1 only, with `q_valid`=0 in that cycle.
  - Earliest `ic_req_valid` is cycle N+1.
- Response captured at cycle M → `q_valid`=1 at M+1. Next request is possible at M+1.
- `q_load` is never asserted on consecutive cycles unless redirects are on consecutive cycles; the last redirect wins.
- Response latency is arbitrary (≥1 cycle after request acceptance). `ic_req_ready` may be held low indefinitely; `ic_req_valid` then stays high unless a redirect arrives.

## Configuration
- `FETCH_LINE_STREAMER_STATS_EN` defined:
  - `lines_delivered` counts `q_valid && q_ready` handshakes.
  - `lines_dropped` counts responses discarded in DROP or by a same-cycle redirect.
  - Both are 16-bit, saturating at 0xFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Test plan
- Reset, redirect to 0x00001005, `ic_req_ready`=1, 2-cycle response latency, `q_ready`=1 → `q_load` pulse with `q_load_address`=0x05. Requests go to 0x00001000, 0x00001010, 0x00001020 in order, and the lines are delivered unchanged and in order.
- Queue backpressure: `q_ready`=0 after the first line → exactly one further request is withheld, `q_valid` stays high with stable `q_data`, and fetching resumes the cycle after `q_ready`=1.
- Redirect to 0x00002000 while in WAIT for 0x00001010 → the response is dropped and never reaches `q_valid`. The next request is 0x00002000, and `lines_dropped`=1 with stats enabled.
- Redirect in the same cycle as `ic_rsp_valid` → the response is dropped, REQ is entered, and the next request address is the redirect target's line.
- Wrap: redirect to 0xFFFFFFF8 → requests 0xFFFFFFF0 then 0x00000000, with `q_load_address`=0x08.
- Async reset asserted in WAIT → outputs go to 0 immediately. A response arriving after reset deasserts is ignored, and no request is issued until a redirect.
